dot_product_sequencer: RTL

DOT_PRODUCT_SEQUENCER -- requirements
Module: dot_product_sequencer

---
 rtl/dotp_pkg.sv | 25 ++
 rtl/dot_product_sequencer_if.sv | 62 ++++++
 rtl/dotp_mac.sv | 41 ++++
 rtl/dot_product_sequencer.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/dotp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dotp_pkg
// Description : Shared types and helpers for the dot-product sequencer:
//               FSM state encoding and accumulator width calculation.
// Revision    : 1.0 - initial release
// ============================================================================
package dotp_pkg;

  // Sequencer phases: load vectors, kick the wrapper, read back, present result
  typedef enum logic [1:0] {
    DOTP_LOAD = 2'd0,
    DOTP_KICK = 2'd1,
    DOTP_READ = 2'd2,
    DOTP_OUT  = 2'd3
  } dotp_state_t;

  // Accumulator width wide enough that summing VECTOR_WIDTH full products
  // can never overflow
  function automatic int dotp_acc_width(input int data_width, input int vector_width);
    return 2 * data_width + $clog2(vector_width);
  endfunction

endpackage
`default_nettype wire

// File: rtl/dot_product_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : dot_product_sequencer_if
// Description : Bundles the element stream, memory-wrapper bus and result
//               handshake of the dot-product sequencer. The slave modport is
//               the sequencer's view, master is the surrounding system's view.
// Revision    : 1.0 - initial release
// ============================================================================
interface dot_product_sequencer_if
  import dotp_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int VECTOR_WIDTH = 4,
  parameter int ADDR_WIDTH   = 5
);
  localparam int ACC_WIDTH = dotp_acc_width(DATA_WIDTH, VECTOR_WIDTH);

  // element stream
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_a;
  logic [DATA_WIDTH-1:0] in_b;
  // memory wrapper write side
  logic                  mem_write_en;
  logic [ADDR_WIDTH-1:0] mem_write_addr;
  logic [DATA_WIDTH-1:0] mem_data_a;
  logic [DATA_WIDTH-1:0] mem_data_b;
  // memory wrapper read side
  logic                  mem_start_reading;
  logic                  mem_reading_done;
  logic                  mem_data_valid;
  logic [DATA_WIDTH-1:0] mem1_output;
  logic [DATA_WIDTH-1:0] mem2_output;
  // result handshake and status
  logic [ACC_WIDTH-1:0]  result;
  logic                  result_valid;
  logic                  result_ready;
  logic                  busy;
  logic                  err;

  modport slave (
    input  in_valid, in_a, in_b,
    input  mem_reading_done, mem_data_valid, mem1_output, mem2_output,
    input  result_ready,
    output in_ready,
    output mem_write_en, mem_write_addr, mem_data_a, mem_data_b,
    output mem_start_reading,
    output result, result_valid, busy, err
  );

  modport master (
    output in_valid, in_a, in_b,
    output mem_reading_done, mem_data_valid, mem1_output, mem2_output,
    output result_ready,
    input  in_ready,
    input  mem_write_en, mem_write_addr, mem_data_a, mem_data_b,
    input  mem_start_reading,
    input  result, result_valid, busy, err
  );

endinterface
`default_nettype wire

// File: rtl/dotp_mac.sv
`default_nettype none
// ============================================================================
// Module      : dotp_mac
// Description : Unsigned multiply-accumulate. clear_i zeroes the accumulator,
//               en_i adds a_i*b_i. clear_i has priority over en_i.
// Revision    : 1.0 - initial release
// ============================================================================
module dotp_mac #(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 18
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear_i,
  input  logic                  en_i,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  output logic [ACC_WIDTH-1:0]  acc_o
);

  logic [2*DATA_WIDTH-1:0] w_prod;
  logic [ACC_WIDTH-1:0]    acc_q;

  // operands zero-extended so the full double-width product is kept
  assign w_prod = {{DATA_WIDTH{1'b0}}, a_i} * {{DATA_WIDTH{1'b0}}, b_i};

  // accumulate one product per enabled cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else if (clear_i) begin
      acc_q <= '0;
    end else if (en_i) begin
      acc_q <= acc_q + ACC_WIDTH'(w_prod);
    end
  end

  assign acc_o = acc_q;

endmodule
`default_nettype wire

// File: rtl/dot_product_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : dot_product_sequencer
// Description : Streams two vectors into a memory wrapper, kicks a read-back,
//               accumulates the element products and presents the dot
//               product on a valid/ready handshake.
//               Optional build macro DOTP_SEQ_TIMEOUT_EN adds a read-phase
//               watchdog of TIMEOUT_CYCLES cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module dot_product_sequencer
  import dotp_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int VECTOR_WIDTH   = 4,
  parameter int ADDR_WIDTH     = 5,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  dot_product_sequencer_if.slave bus
);

  localparam int ACC_WIDTH = dotp_acc_width(DATA_WIDTH, VECTOR_WIDTH);
  localparam int CNT_WIDTH = $clog2(VECTOR_WIDTH + 1);
  localparam logic [CNT_WIDTH-1:0] C_LAST = CNT_WIDTH'(VECTOR_WIDTH - 1);
  localparam logic [CNT_WIDTH-1:0] C_FULL = CNT_WIDTH'(VECTOR_WIDTH);

  localparam logic [1:0] S_LOAD = DOTP_LOAD;
  localparam logic [1:0] S_KICK = DOTP_KICK;
  localparam logic [1:0] S_READ = DOTP_READ;
  localparam logic [1:0] S_OUT  = DOTP_OUT;

  logic [1:0]            state_q, state_d;
  logic [CNT_WIDTH-1:0]  beat_q, beat_d;
  logic [CNT_WIDTH-1:0]  rd_q, rd_d;
  logic                  err_q, err_d;
  logic                  in_ready_q;
  logic                  wr_en_q;
  logic [ADDR_WIDTH-1:0] wr_addr_q;
  logic [DATA_WIDTH-1:0] wr_a_q, wr_b_q;
  logic                  w_accept;
  logic                  w_take;
  logic [CNT_WIDTH-1:0]  w_rd_after;
  logic [ACC_WIDTH-1:0]  w_acc;

  assign w_accept   = (state_q == S_LOAD) && in_ready_q && bus.in_valid;
  // a read beat counts only in READ and only until the vector is complete
  assign w_take     = (state_q == S_READ) && bus.mem_data_valid && (rd_q < C_FULL);
  assign w_rd_after = rd_q + CNT_WIDTH'(w_take);

`ifdef DOTP_SEQ_TIMEOUT_EN
  localparam int WD_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_WIDTH-1:0] C_WD_LAST = WD_WIDTH'(TIMEOUT_CYCLES - 1);
  logic [WD_WIDTH-1:0] wd_q, wd_d;

  // watchdog counts READ cycles and is zero whenever READ is left
  always_comb begin
    wd_d = '0;
    if (state_q == S_READ) wd_d = wd_q + 1'b1;
  end

  // watchdog register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wd_q <= '0;
    else        wd_q <= wd_d;
  end
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

  // next-state, counter and error logic
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    rd_d    = rd_q;
    err_d   = err_q;
    case (state_q)
      S_LOAD: begin
        if (w_accept) begin
          beat_d = beat_q + 1'b1;
          if (beat_q == C_LAST) begin
            beat_d  = '0;
            state_d = S_KICK;
          end
        end
      end
      S_KICK: begin
        beat_d  = '0;
        rd_d    = '0;
        err_d   = 1'b0;
        state_d = S_READ;
      end
      S_READ: begin
        if (bus.mem_data_valid && !w_take) err_d = 1'b1;
        rd_d = w_rd_after;
        // a beat arriving together with done is counted before the check
        if (bus.mem_reading_done) begin
          state_d = S_OUT;
          if (w_rd_after != C_FULL) err_d = 1'b1;
        end
`ifdef DOTP_SEQ_TIMEOUT_EN
        else if (wd_q == C_WD_LAST) begin
          err_d   = 1'b1;
          state_d = S_OUT;
        end
`endif
      end
      S_OUT: begin
        if (bus.result_ready) state_d = S_LOAD;
      end
      default: state_d = S_LOAD;
    endcase
  end

  // state, counters, error flag and ready
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_LOAD;
      beat_q     <= '0;
      rd_q       <= '0;
      err_q      <= 1'b0;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      rd_q       <= rd_d;
      err_q      <= err_d;
      in_ready_q <= (state_d == S_LOAD);
    end
  end

  // registered write port toward the memory wrapper
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_a_q    <= '0;
      wr_b_q    <= '0;
    end else begin
      wr_en_q <= w_accept;
      if (w_accept) begin
        wr_addr_q <= ADDR_WIDTH'(beat_q);
        wr_a_q    <= bus.in_a;
        wr_b_q    <= bus.in_b;
      end
    end
  end

  dotp_mac #(
    .DATA_WIDTH (DATA_WIDTH),
    .ACC_WIDTH  (ACC_WIDTH)
  ) u_mac (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear_i (state_q == S_KICK),
    .en_i    (w_take),
    .a_i     (bus.mem1_output),
    .b_i     (bus.mem2_output),
    .acc_o   (w_acc)
  );

  assign bus.in_ready          = in_ready_q;
  assign bus.mem_write_en      = wr_en_q;
  assign bus.mem_write_addr    = wr_addr_q;
  assign bus.mem_data_a        = wr_a_q;
  assign bus.mem_data_b        = wr_b_q;
  assign bus.mem_start_reading = (state_q == S_KICK);
  assign bus.result            = w_acc;
  assign bus.result_valid      = (state_q == S_OUT);
  assign bus.busy              = (state_q != S_LOAD);
  assign bus.err               = err_q;

endmodule
`default_nettype wire
